// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter and its round-robin sub-block.
//   REG_ADDR_W        : register-file address width
//   WB_REQ_IU/LSU/MD  : requester index assignment on the arbiter's request vectors
//   wb_req_t          : one writeback request (destination register + result)
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_XLEN    = 32;

  localparam int unsigned WB_REQ_IU  = 0;
  localparam int unsigned WB_REQ_LSU = 1;
  localparam int unsigned WB_REQ_MD  = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [WB_XLEN-1:0]    wdata;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts at the pointer and wraps modulo NREQ.
// The pointer moves to one past the winner on every cycle a grant is issued.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pointer returns to 0)
//   en       : grants are issued only while en is high
//   req      : request vector
//   gnt      : one-hot grant, all zero when en is low or nothing is requested
//   gnt_idx  : index of the winning requester (meaningful only when gnt != 0)
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr_q;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (!found && req[cand[IdxW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IdxW-1:0];
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && found) begin
      ptr_d = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port among the
// execution units (0 integer, 1 load, 2 mul/div). One request is accepted per
// cycle by round-robin and registered into a one-entry output stage.
// Writes to x0 are accepted but never presented on the write port.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_req_valid       : per-requester writeback valid
//   o_req_ready       : per-requester accept, one-hot or zero
//   i_req_waddr/wdata : per-requester destination register and result
//   o_wb_rd_w*        : register-file write valid/address/data
//   i_wb_rd_wready    : register-file port can accept
//   o_stall_cnt       : per-requester saturating stall counters
//                       (only when WB_ARB_PERF_EN is defined)
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  i_req_valid,
  output logic [NREQ-1:0]                  o_req_ready,
  input  logic [NREQ-1:0][REG_ADDR_W-1:0]  i_req_waddr,
  input  logic [NREQ-1:0][XLEN-1:0]        i_req_wdata,
  output logic                             o_wb_rd_wvalid,
  output logic [REG_ADDR_W-1:0]            o_wb_rd_waddr,
  output logic [XLEN-1:0]                  o_wb_rd_wdata,
  input  logic                             i_wb_rd_wready
`ifdef WB_ARB_PERF_EN
  ,
  output logic [NREQ-1:0][31:0]            o_stall_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic                  out_free;
  logic                  arb_en;
  logic                  accept;
  logic [NREQ-1:0]       gnt;
  logic [IdxW-1:0]       gnt_idx;
  logic                  wvalid_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [XLEN-1:0]       wdata_q;

  // The stage can take a new entry when empty or when it drains this cycle.
  assign out_free = !wvalid_q || i_wb_rd_wready;
  // Holding ready low in reset keeps requesters from seeing a phantom accept.
  assign arb_en   = out_free && !rst;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req     (i_req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign o_req_ready = gnt;
  assign accept      = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else if (out_free) begin
      if (accept) begin
        wvalid_q <= (i_req_waddr[gnt_idx] != '0);
        waddr_q  <= i_req_waddr[gnt_idx];
        wdata_q  <= i_req_wdata[gnt_idx];
      end else begin
        wvalid_q <= 1'b0;
      end
    end
  end

  assign o_wb_rd_wvalid = wvalid_q;
  assign o_wb_rd_waddr  = waddr_q;
  assign o_wb_rd_wdata  = wdata_q;

`ifdef WB_ARB_PERF_EN
  logic [NREQ-1:0][31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (i_req_valid[i] && !gnt[i] && (stall_cnt_q[i] != '1)) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  // No stall counters in this build.
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: reset, single request, x0 write,
// round-robin rotation, backpressure, mid-operation reset and (with
// WB_ARB_PERF_EN) stall counters.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREQ = 3;

  logic                            clk;
  logic                            rst;
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0][REG_ADDR_W-1:0] req_waddr;
  logic [NREQ-1:0][XLEN-1:0]       req_wdata;
  logic                            wb_wvalid;
  logic [REG_ADDR_W-1:0]           wb_waddr;
  logic [XLEN-1:0]                 wb_wdata;
  logic                            wb_wready;
`ifdef WB_ARB_PERF_EN
  logic [NREQ-1:0][31:0]           stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(
    .XLEN (XLEN),
    .NREQ (NREQ)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_waddr    (req_waddr),
    .i_req_wdata    (req_wdata),
    .o_wb_rd_wvalid (wb_wvalid),
    .o_wb_rd_waddr  (wb_waddr),
    .o_wb_rd_wdata  (wb_wdata),
    .i_wb_rd_wready (wb_wready)
`ifdef WB_ARB_PERF_EN
    ,
    .o_stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    wb_wready = 1'b1;

    // Reset state, with requests present to show ready stays low.
    tick();
    req_valid = 3'b111;
    req_waddr = {5'd3, 5'd2, 5'd1};
    tick();
    check_eq("rst_ready", 64'(req_ready), 64'h0);
    check_eq("rst_wvalid", 64'(wb_wvalid), 64'h0);
    check_eq("rst_waddr", 64'(wb_waddr), 64'h0);
    check_eq("rst_wdata", 64'(wb_wdata), 64'h0);

    // Single request from the integer unit.
    rst          = 1'b0;
    req_valid    = 3'b001;
    req_waddr[0] = 5'd5;
    req_wdata[0] = 32'hDEADBEEF;
    #1;
    check_eq("single_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    check_eq("single_wvalid", 64'(wb_wvalid), 64'h1);
    check_eq("single_waddr", 64'(wb_waddr), 64'h5);
    check_eq("single_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    tick();
    check_eq("single_wvalid_drop", 64'(wb_wvalid), 64'h0);
    check_eq("single_waddr_hold", 64'(wb_waddr), 64'h5);

    // x0 write from the load unit (pointer is now 1).
    req_valid    = 3'b010;
    req_waddr[1] = 5'd0;
    req_wdata[1] = 32'h1234;
    #1;
    check_eq("x0_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    check_eq("x0_wvalid", 64'(wb_wvalid), 64'h0);

    // All three valid: pointer sits at 2 after the x0 accept, then rotates.
    for (int i = 0; i < NREQ; i++) begin
      req_waddr[i] = REG_ADDR_W'(i + 1);
      req_wdata[i] = 32'h1000_0000 + XLEN'(i);
    end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      int unsigned g;
      g = (2 + k) % 3;
      #1;
      check_eq($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << g));
      tick();
      check_eq($sformatf("rr_wvalid_%0d", k), 64'(wb_wvalid), 64'h1);
      check_eq($sformatf("rr_waddr_%0d", k), 64'(wb_waddr), 64'(g + 1));
      check_eq($sformatf("rr_wdata_%0d", k), 64'(wb_wdata), 64'h1000_0000 + 64'(g));
    end

    // Backpressure: load the stage with 7/A5A5A5A5, then stall it.
    req_valid    = 3'b001;
    req_waddr[0] = 5'd7;
    req_wdata[0] = 32'hA5A5A5A5;
    #1;
    check_eq("bp_load_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid    = 3'b100;
    req_waddr[2] = 5'd9;
    req_wdata[2] = 32'hCAFEF00D;
    wb_wready    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("bp_ready_%0d", c), 64'(req_ready), 64'h0);
      check_eq($sformatf("bp_wvalid_%0d", c), 64'(wb_wvalid), 64'h1);
      check_eq($sformatf("bp_waddr_%0d", c), 64'(wb_waddr), 64'h7);
      check_eq($sformatf("bp_wdata_%0d", c), 64'(wb_wdata), 64'hA5A5A5A5);
      tick();
    end
    wb_wready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    check_eq("bp_next_wvalid", 64'(wb_wvalid), 64'h1);
    check_eq("bp_next_waddr", 64'(wb_waddr), 64'h9);
    check_eq("bp_next_wdata", 64'(wb_wdata), 64'hCAFEF00D);

    // Reset mid-operation: move the pointer off 0 and fill the stage first.
    req_valid = 3'b111;
    #1;
    check_eq("mid_pre_ready", 64'(req_ready), 64'h1);
    tick();
    check_eq("mid_pre_wvalid", 64'(wb_wvalid), 64'h1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 64'(req_ready), 64'h0);
    tick();
    check_eq("mid_wvalid", 64'(wb_wvalid), 64'h0);
    check_eq("mid_waddr", 64'(wb_waddr), 64'h0);
    check_eq("mid_wdata", 64'(wb_wdata), 64'h0);
    check_eq("mid_ready", 64'(req_ready), 64'h0);
    rst = 1'b0;
    #1;
    check_eq("mid_first_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;

`ifdef WB_ARB_PERF_EN
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 3'b011;
    repeat (4) tick();
    req_valid = '0;
    #1;
    check_eq("perf_cnt0", 64'(stall_cnt[0]), 64'd2);
    check_eq("perf_cnt1", 64'(stall_cnt[1]), 64'd2);
    check_eq("perf_cnt2", 64'(stall_cnt[2]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
